aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Sequencing controller for the iterative AES cipher datapath feeding the text_out register bank.
- Accepts a block-start handshake and steps the datapath through the initial AddRoundKey, NR-1 full rounds and the final round (no MixColumns).
- Drives key-expansion enable and pulses the text_out load strobe.
- Holds the result valid until the consumer accepts it; back-to-back blocks are supported without an idle bubble.

Parameters:
- NR_DEFAULT, 10, round count used when the key-length selection is compiled out (legal values 10, 12, 14).
- RCW, 4, width of the round index output.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  new plaintext/key loaded and ready to start.
- in_ready  out  1  controller can accept a start.
- in_keylen  in  2  00=128b, 01=192b, 10=256b, 11=reserved; sampled on start handshake.
- out_valid  out  1  text_out holds a finished block.
- out_ready  in  1  consumer takes the text_out block.
- dp_init  out  1  datapath performs the initial AddRoundKey this cycle.
- dp_round_en  out  1  datapath performs a round this cycle.
- dp_last  out  1  current round is the final round (MixColumns bypassed).
- dp_round  out  RCW  current round index, 0..NR.
- kexp_en  out  1  key schedule advances this cycle.
- text_out_ld  out  1  one-cycle load strobe for the text_out register bank.
- busy  out  1  a block is in flight (state is not IDLE or OUT).

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, dp_init/dp_round_en/dp_last/kexp_en/text_out_ld=0, dp_round=0, busy=0, nr_q=NR_DEFAULT.
- Start handshake: start = in_valid & in_ready.
- in_ready = (state==IDLE) | (state==OUT & out_ready).
- States and transitions:
  - IDLE: on start, latch nr_q, go to INIT; otherwise stay.
  - INIT: dp_init=1, kexp_en=1, dp_round=0; next ROUND, rc=1.
  - ROUND: dp_round_en=1, kexp_en=1, dp_round=rc. If rc==nr_q-1, go to FINAL; otherwise rc+1.
  - FINAL: dp_round_en=1, dp_last=1, text_out_ld=1, dp_round=nr_q. Next state OUT, and out_valid is set.
  - OUT: out_valid=1 and held until out_ready.
    - out_ready & ~in_valid: clear out_valid, go to IDLE.
    - out_ready & in_valid: clear out_valid and restart in the same cycle (latch new nr_q, go to INIT). No bubble.
    - ~out_ready: stay; in_valid is ignored.
- Latency: the start-handshake cycle is T. out_valid rises at the edge ending cycle T+nr_q+1, so it is visible in cycle T+nr_q+2 (12 cycles for AES-128).
- Throughput: one block per nr_q+2 cycles when out_ready is held high.
- Signal registration: all dp_*/kexp_en/text_out_ld are decoded from registered state (Moore). Exactly one of dp_init/dp_round_en is high in any active cycle.
- in_valid during busy: ignored, in_ready=0; no abort path.
- Reset mid-operation: returns to IDLE next cycle. No text_out_ld is issued, and any pending out_valid is dropped.
- rc does not wrap: the FINAL transition happens strictly at rc==nr_q-1, and rc is cleared on entry to INIT.

Optional Feature:
- Macro: AES_KEYLEN_SEL_EN.
- Defined: nr_q = 10/12/14 from in_keylen at start. Reserved code 11 is treated as 128b (nr_q=10).
- Undefined: in_keylen is ignored and nr_q = NR_DEFAULT always. The port remains present for interface stability.

Test Plan:
- Reset then single block: in_valid=1 for one cycle with in_keylen=00 -> dp_init in cycle T+1; dp_round_en cycles T+2..T+11 with dp_round 1..10; dp_last and text_out_ld only at dp_round=10; out_valid from T+12.
- Output stall: hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid stays 1, in_ready=0, no new dp_init. Raise out_ready -> same-cycle restart, dp_init next cycle.
- Back-to-back: out_ready=1 and in_valid=1 continuously with keylen=00 -> dp_init pulses every 12 cycles; text_out_ld count equals the number of start handshakes.
- Key lengths (macro defined): keylen=01 -> last dp_round=12, out_valid at T+14. keylen=10 -> 14, out_valid at T+16. keylen=11 -> behaves as 10.
- Reset mid-round: assert rst at dp_round=5 -> next cycle in IDLE, all strobes 0, in_ready=1; no text_out_ld was seen.
- Macro undefined with NR_DEFAULT=14 and keylen=00 -> 14 rounds, dp_last at dp_round=14.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Sequencing controller for the iterative AES datapath: INIT, NR-1 rounds, FINAL, then holds text_out valid.
// Optional macro AES_KEYLEN_SEL_EN selects the round count (10/12/14) from in_keylen at start.
module aes_round_ctrl #(
  parameter int NR_DEFAULT = 10,
  parameter int RCW        = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_keylen,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           dp_init,
  output logic           dp_round_en,
  output logic           dp_last,
  output logic [RCW-1:0] dp_round,
  output logic           kexp_en,
  output logic           text_out_ld,
  output logic           busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [RCW-1:0] rc_q, rc_d;
  logic [RCW-1:0] nr_q, nr_d;
  logic [RCW-1:0] nr_sel;
  logic           start;

`ifdef AES_KEYLEN_SEL_EN
  // Reserved code 2'b11 falls back to the 128-bit round count.
  always_comb begin
    case (in_keylen)
      2'b01:   nr_sel = RCW'(12);
      2'b10:   nr_sel = RCW'(14);
      default: nr_sel = RCW'(10);
    endcase
  end
`else
  logic keylen_unused;
  assign keylen_unused = ^in_keylen;
  assign nr_sel        = RCW'(NR_DEFAULT);
`endif

  assign in_ready = (state_q == S_IDLE) | ((state_q == S_OUT) & out_ready);
  assign start    = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    nr_d    = nr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          nr_d    = nr_sel;
          rc_d    = '0;
        end
      end
      S_INIT: begin
        state_d = S_ROUND;
        rc_d    = RCW'(1);
      end
      S_ROUND: begin
        if (rc_q == nr_q - RCW'(1)) state_d = S_FINAL;
        else                        rc_d    = rc_q + RCW'(1);
      end
      S_FINAL: state_d = S_OUT;
      S_OUT: begin
        // Accept and restart in the same cycle so back-to-back blocks see no bubble.
        if (out_ready) begin
          if (in_valid) begin
            state_d = S_INIT;
            nr_d    = nr_sel;
            rc_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rc_q    <= '0;
      nr_q    <= RCW'(NR_DEFAULT);
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      nr_q    <= nr_d;
    end
  end

  // Moore decode: every strobe follows registered state only.
  always_comb begin
    dp_init     = 1'b0;
    dp_round_en = 1'b0;
    dp_last     = 1'b0;
    dp_round    = '0;
    kexp_en     = 1'b0;
    text_out_ld = 1'b0;
    case (state_q)
      S_INIT: begin
        dp_init = 1'b1;
        kexp_en = 1'b1;
      end
      S_ROUND: begin
        dp_round_en = 1'b1;
        kexp_en     = 1'b1;
        dp_round    = rc_q;
      end
      S_FINAL: begin
        dp_round_en = 1'b1;
        dp_last     = 1'b1;
        text_out_ld = 1'b1;
        dp_round    = nr_q;
      end
      default: ;
    endcase
  end

  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q == S_INIT) | (state_q == S_ROUND) | (state_q == S_FINAL);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: cycle-offset reference model, directed steps then random traffic.
module tb_aes_round_ctrl;
  localparam int NRD = 10;
  localparam int RCW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [1:0]     in_keylen = 2'b00;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           dp_init, dp_round_en, dp_last, kexp_en, text_out_ld, busy;
  logic [RCW-1:0] dp_round;

  aes_round_ctrl #(.NR_DEFAULT(NRD), .RCW(RCW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_keylen(in_keylen), .out_valid(out_valid), .out_ready(out_ready),
    .dp_init(dp_init), .dp_round_en(dp_round_en), .dp_last(dp_last),
    .dp_round(dp_round), .kexp_en(kexp_en), .text_out_ld(text_out_ld), .busy(busy)
  );

  always #5 clk = ~clk;

  int    errs = 0;
  int    checks = 0;
  int    cyc_n = 0;
  int    ph = -1;     // cycles since the start handshake; -1 when idle
  int    nr = NRD;
  int    exp_ld = 0;
  int    obs_ld = 0;
  string tag = "reset";

  function automatic int nr_of(input logic [1:0] kl);
`ifdef AES_KEYLEN_SEL_EN
    if (kl == 2'b01) return 12;
    if (kl == 2'b10) return 14;
    return 10;
`else
    return NRD;
`endif
  endfunction

  // {in_ready,out_valid,dp_init,dp_round_en,dp_last,dp_round,kexp_en,text_out_ld,busy}
  function automatic logic [11:0] exp_vec(input int p, input int n, input logic ordy);
    if (p < 0)          return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    if (p == 1)         return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1};
    if (p <= n)         return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'(p - 1), 1'b1, 1'b0, 1'b1};
    if (p == n + 1)     return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'(n), 1'b0, 1'b1, 1'b1};
    return {ordy, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
  endfunction

  task automatic cyc(input logic iv, input logic [1:0] kl, input logic ordy, input logic r);
    logic [11:0] obs, expv;
    in_valid = iv; in_keylen = kl; out_ready = ordy; rst = r;
    #1;
    obs  = {in_ready, out_valid, dp_init, dp_round_en, dp_last, dp_round, kexp_en, text_out_ld, busy};
    expv = exp_vec(ph, nr, ordy);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s cyc=%0d ph=%0d obs=%h exp=%h", tag, cyc_n, ph, obs, expv);
    end
    if (ph == nr + 1) exp_ld++;
    if (text_out_ld === 1'b1) obs_ld++;
    if (r) ph = -1;
    else if (ph < 0) begin
      if (iv) begin ph = 1; nr = nr_of(kl); end
    end else if (ph >= nr + 2) begin
      if (ordy) begin
        if (iv) begin ph = 1; nr = nr_of(kl); end
        else ph = -1;
      end
    end else ph++;
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic run_to_out(input logic [1:0] kl);
    cyc(1'b1, kl, 1'b0, 1'b0);
    for (int i = 0; i < 20 && ph < nr + 2; i++) cyc(1'b0, kl, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    tag = "reset";
    cyc(1'b1, 2'b00, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);

    tag = "single128";
    run_to_out(2'b00);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);

    tag = "stall";
    run_to_out(2'b00);
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'b00, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);

    tag = "b2b";
    for (int i = 0; i < 40; i++) cyc(1'b1, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) cyc(1'b0, 2'b00, 1'b1, 1'b0);

    tag = "keylen";
    for (int k = 1; k < 4; k++) begin
      run_to_out(2'(k));
      cyc(1'b0, 2'b00, 1'b1, 1'b0);
    end

    tag = "rst_mid";
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 20 && ph != 6; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);

    tag = "random";
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));

    tag = "ld_count";
    checks++;
    assert (obs_ld == exp_ld) else begin
      errs++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs_ld, exp_ld);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
